// File: rtl/iprf_wb_arb_if.sv
// Writeback packet type and the requester / PRF write-port bus of iprf_wb_arb.
// Perf counter signals exist only when IPRF_WB_ARB_PERF_EN is defined.
package iprf_wb_arb_pkg;
  typedef struct packed {
    logic [6:0]  pdst;
    logic [31:0] data;
  } t_prf_wr_pkt;
endpackage

interface iprf_wb_arb_if
  import iprf_wb_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int NUM_WR_PORTS = 1,
  parameter int Q_DEPTH      = 4
);
  localparam int OCC_W = $clog2(Q_DEPTH + 1);

  logic                           nuke_rb1;
  logic [NUM_REQ-1:0]             req_valid;
  t_prf_wr_pkt [NUM_REQ-1:0]      req_pkt;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_WR_PORTS-1:0]        wr_en;
  t_prf_wr_pkt [NUM_WR_PORTS-1:0] wr_pkt;
  logic [NUM_REQ-1:0][OCC_W-1:0]  q_occ;
`ifdef IPRF_WB_ARB_PERF_EN
  logic [NUM_REQ-1:0][31:0]       perf_stall_cnt;
  logic [NUM_REQ-1:0][31:0]       perf_full_cnt;

  modport master (output nuke_rb1, req_valid, req_pkt,
                  input req_ready, wr_en, wr_pkt, q_occ, perf_stall_cnt, perf_full_cnt);
  modport slave  (input nuke_rb1, req_valid, req_pkt,
                  output req_ready, wr_en, wr_pkt, q_occ, perf_stall_cnt, perf_full_cnt);
`else
  modport master (output nuke_rb1, req_valid, req_pkt,
                  input req_ready, wr_en, wr_pkt, q_occ);
  modport slave  (input nuke_rb1, req_valid, req_pkt,
                  output req_ready, wr_en, wr_pkt, q_occ);
`endif
endinterface

// File: rtl/iprf_wb_arb.sv
// Integer-PRF writeback arbiter: per-requester skid FIFOs drained round-robin onto
// registered PRF write ports. IPRF_WB_ARB_PERF_EN adds saturating stall/full counters.
module iprf_wb_arb
  import iprf_wb_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int NUM_WR_PORTS = 1,
  parameter int Q_DEPTH      = 4
) (
  input logic         clk,
  input logic         reset,
  iprf_wb_arb_if.slave bus
);
  localparam int RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(Q_DEPTH);
  localparam int OCC_W = $clog2(Q_DEPTH + 1);

  logic [NUM_REQ-1:0]      ready;
  logic [NUM_REQ-1:0]      push;
  logic [NUM_REQ-1:0]      pop;
  logic [OCC_W-1:0]        occ [NUM_REQ];
  t_prf_wr_pkt             head [NUM_REQ];
  logic [RR_W-1:0]         rr_ptr_reg;
  logic [RR_W-1:0]         rr_ptr_next;
  logic [NUM_WR_PORTS-1:0] port_vld;
  logic [RR_W-1:0]         port_src [NUM_WR_PORTS];
  logic [NUM_WR_PORTS-1:0] wr_en_reg;
  t_prf_wr_pkt             wr_pkt_reg [NUM_WR_PORTS];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_q
    t_prf_wr_pkt      mem [Q_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [OCC_W-1:0] occ_reg;

    // Ready looks only at registered occupancy, so a pop never frees a slot early.
    assign ready[gi]         = (occ_reg != OCC_W'(Q_DEPTH));
    assign push[gi]          = bus.req_valid[gi] & ready[gi] & ~bus.nuke_rb1;
    assign occ[gi]           = occ_reg;
    assign head[gi]          = mem[rd_ptr_reg];
    assign bus.req_ready[gi] = ready[gi];
    assign bus.q_occ[gi]     = occ_reg;

    always_ff @(posedge clk) begin
      if (push[gi]) mem[wr_ptr_reg] <= bus.req_pkt[gi];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        occ_reg    <= '0;
      end else if (bus.nuke_rb1) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        occ_reg    <= '0;
      end else begin
        if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        case ({push[gi], pop[gi]})
          2'b10:   occ_reg <= occ_reg + 1'b1;
          2'b01:   occ_reg <= occ_reg - 1'b1;
          default: occ_reg <= occ_reg;
        endcase
      end
    end

`ifdef IPRF_WB_ARB_PERF_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] full_cnt_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stall_cnt_reg <= '0;
        full_cnt_reg  <= '0;
      end else begin
        if (occ_reg != '0 && !pop[gi] && stall_cnt_reg != '1) stall_cnt_reg <= stall_cnt_reg + 1'b1;
        if (!ready[gi] && full_cnt_reg != '1) full_cnt_reg <= full_cnt_reg + 1'b1;
      end
    end

    assign bus.perf_stall_cnt[gi] = stall_cnt_reg;
    assign bus.perf_full_cnt[gi]  = full_cnt_reg;
`endif
  end

  // Scan from rr_ptr upward (wrapping) and hand the first non-empty queues to ports in order.
  always_comb begin
    int n;
    int idx;
    pop         = '0;
    port_vld    = '0;
    rr_ptr_next = rr_ptr_reg;
    for (int k = 0; k < NUM_WR_PORTS; k++) port_src[k] = '0;
    n   = 0;
    idx = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(rr_ptr_reg) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!bus.nuke_rb1 && occ[idx] != '0 && n < NUM_WR_PORTS) begin
        pop[idx]      = 1'b1;
        port_vld[n]   = 1'b1;
        port_src[n]   = RR_W'(idx);
        rr_ptr_next   = (idx == NUM_REQ - 1) ? '0 : RR_W'(idx + 1);
        n             = n + 1;
      end
    end
    if (bus.nuke_rb1) rr_ptr_next = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_reg <= '0;
      wr_en_reg  <= '0;
      for (int k = 0; k < NUM_WR_PORTS; k++) wr_pkt_reg[k] <= '0;
    end else begin
      rr_ptr_reg <= rr_ptr_next;
      wr_en_reg  <= port_vld;
      for (int k = 0; k < NUM_WR_PORTS; k++) begin
        if (port_vld[k]) wr_pkt_reg[k] <= head[port_src[k]];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_WR_PORTS; gi++) begin : g_port
    assign bus.wr_en[gi]  = wr_en_reg[gi];
    assign bus.wr_pkt[gi] = wr_pkt_reg[gi];
  end

`ifdef ASSERT
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_chk_q
    a_push_ready: assert property (@(posedge clk) disable iff (reset)
      !(bus.req_valid[gi] && !ready[gi]));
    a_occ_max: assert property (@(posedge clk) disable iff (reset)
      occ[gi] <= OCC_W'(Q_DEPTH));
  end
  for (genvar gi = 0; gi < NUM_WR_PORTS; gi++) begin : g_chk_p
    for (genvar gj = gi + 1; gj < NUM_WR_PORTS; gj++) begin : g_pair
      a_uniq_src: assert property (@(posedge clk) disable iff (reset)
        !(port_vld[gi] && port_vld[gj] && port_src[gi] == port_src[gj]));
    end
  end
`endif
endmodule

// File: tb/tb_iprf_wb_arb.sv
// Bench for iprf_wb_arb: cycle-exact vector table plus scoreboarded multi-cycle sequences.
module tb_iprf_wb_arb;
  import iprf_wb_arb_pkg::*;

  localparam int NUM_REQ      = 2;
  localparam int NUM_WR_PORTS = 1;
  localparam int Q_DEPTH      = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  iprf_wb_arb_if #(.NUM_REQ(NUM_REQ), .NUM_WR_PORTS(NUM_WR_PORTS), .Q_DEPTH(Q_DEPTH)) bus ();

  iprf_wb_arb #(.NUM_REQ(NUM_REQ), .NUM_WR_PORTS(NUM_WR_PORTS), .Q_DEPTH(Q_DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] valid;
    logic [6:0] p0;
    logic [6:0] p1;
    logic       nuke;
    logic [2:0] e_occ0;
    logic [2:0] e_occ1;
    logic [1:0] e_ready;
    logic       e_wr_en;
    logic [6:0] e_pdst;
  } vec_t;

  vec_t        vecs [27];
  int          n_checks = 0;
  int          n_fails  = 0;
  t_prf_wr_pkt sb0 [$];
  t_prf_wr_pkt sb1 [$];
  t_prf_wr_pkt mon_pkt;
  t_prf_wr_pkt mon_exp;
  int          mem_out_cnt = 0;
  int          ex_n;
  int          mem_n;
  int          n;
  logic [1:0]  v;
  logic        saw_full;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic t_prf_wr_pkt mkpkt(input logic src, input logic [6:0] pdst);
    t_prf_wr_pkt p;
    p.pdst = pdst;
    p.data = {7'd0, src, 17'd0, pdst};
    return p;
  endfunction

  // Drive one cycle of stimulus, advance to just after the edge, then go idle.
  task automatic cycle(input logic [1:0] vv, input logic [6:0] p0, input logic [6:0] p1, input logic nk);
    bus.req_valid  = vv;
    bus.req_pkt[0] = mkpkt(1'b0, p0);
    bus.req_pkt[1] = mkpkt(1'b1, p1);
    bus.nuke_rb1   = nk;
    if (!nk) begin
      if (vv[0]) sb0.push_back(mkpkt(1'b0, p0));
      if (vv[1]) sb1.push_back(mkpkt(1'b1, p1));
    end
    @(posedge clk);
    #1;
    if (nk) begin
      sb0.delete();
      sb1.delete();
    end
    bus.req_valid = 2'b00;
    bus.nuke_rb1  = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((sb0.size() != 0 || sb1.size() != 0) && k < 40) begin
      cycle(2'b00, 7'd0, 7'd0, 1'b0);
      k++;
    end
    check(name, 64'(sb0.size() + sb1.size()), 64'd0);
  endtask

  // Scoreboard: every write-port beat must be the oldest outstanding packet of its requester.
  always @(negedge clk) begin
    if (!reset && bus.wr_en[0]) begin
      mon_pkt = bus.wr_pkt[0];
      if (mon_pkt.data[24]) begin
        mem_out_cnt++;
        check("sb_mem_nonempty", 64'(sb1.size() != 0), 64'd1);
        if (sb1.size() != 0) begin
          mon_exp = sb1.pop_front();
          check("sb_mem_pkt", 64'(mon_pkt), 64'(mon_exp));
        end
      end else begin
        check("sb_ex_nonempty", 64'(sb0.size() != 0), 64'd1);
        if (sb0.size() != 0) begin
          mon_exp = sb0.pop_front();
          check("sb_ex_pkt", 64'(mon_pkt), 64'(mon_exp));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          valid  p0     p1     nk     occ0  occ1  ready  wr_en pdst
    vecs[0]  = '{2'b11, 7'd3,  7'd7,  1'b0, 3'd1, 3'd1, 2'b11, 1'b0, 7'd0};
    vecs[1]  = '{2'b00, 7'd0,  7'd0,  1'b0, 3'd0, 3'd1, 2'b11, 1'b1, 7'd3};
    vecs[2]  = '{2'b00, 7'd0,  7'd0,  1'b0, 3'd0, 3'd0, 2'b11, 1'b1, 7'd7};
    vecs[3]  = '{2'b00, 7'd0,  7'd0,  1'b0, 3'd0, 3'd0, 2'b11, 1'b0, 7'd7};
    vecs[4]  = '{2'b01, 7'd5,  7'd0,  1'b0, 3'd1, 3'd0, 2'b11, 1'b0, 7'd7};
    vecs[5]  = '{2'b00, 7'd0,  7'd0,  1'b0, 3'd0, 3'd0, 2'b11, 1'b1, 7'd5};
    vecs[6]  = '{2'b00, 7'd0,  7'd0,  1'b0, 3'd0, 3'd0, 2'b11, 1'b0, 7'd5};
    vecs[7]  = '{2'b11, 7'd10, 7'd11, 1'b0, 3'd1, 3'd1, 2'b11, 1'b0, 7'd5};
    vecs[8]  = '{2'b00, 7'd0,  7'd0,  1'b0, 3'd1, 3'd0, 2'b11, 1'b1, 7'd11};
    vecs[9]  = '{2'b00, 7'd0,  7'd0,  1'b0, 3'd0, 3'd0, 2'b11, 1'b1, 7'd10};
    vecs[10] = '{2'b00, 7'd0,  7'd0,  1'b0, 3'd0, 3'd0, 2'b11, 1'b0, 7'd10};
    vecs[11] = '{2'b01, 7'd20, 7'd0,  1'b0, 3'd1, 3'd0, 2'b11, 1'b0, 7'd10};
    vecs[12] = '{2'b10, 7'd0,  7'd21, 1'b0, 3'd0, 3'd1, 2'b11, 1'b1, 7'd20};
    vecs[13] = '{2'b00, 7'd0,  7'd0,  1'b0, 3'd0, 3'd0, 2'b11, 1'b1, 7'd21};
    vecs[14] = '{2'b11, 7'd22, 7'd23, 1'b0, 3'd1, 3'd1, 2'b11, 1'b0, 7'd21};
    vecs[15] = '{2'b00, 7'd0,  7'd0,  1'b0, 3'd0, 3'd1, 2'b11, 1'b1, 7'd22};
    vecs[16] = '{2'b00, 7'd0,  7'd0,  1'b0, 3'd0, 3'd0, 2'b11, 1'b1, 7'd23};
    vecs[17] = '{2'b00, 7'd0,  7'd0,  1'b0, 3'd0, 3'd0, 2'b11, 1'b0, 7'd23};
    vecs[18] = '{2'b11, 7'd30, 7'd31, 1'b0, 3'd1, 3'd1, 2'b11, 1'b0, 7'd23};
    vecs[19] = '{2'b11, 7'd32, 7'd33, 1'b0, 3'd1, 3'd2, 2'b11, 1'b1, 7'd30};
    vecs[20] = '{2'b11, 7'd40, 7'd41, 1'b1, 3'd0, 3'd0, 2'b11, 1'b0, 7'd30};
    vecs[21] = '{2'b00, 7'd0,  7'd0,  1'b0, 3'd0, 3'd0, 2'b11, 1'b0, 7'd30};
    vecs[22] = '{2'b11, 7'd50, 7'd51, 1'b0, 3'd1, 3'd1, 2'b11, 1'b0, 7'd30};
    vecs[23] = '{2'b00, 7'd0,  7'd0,  1'b0, 3'd0, 3'd1, 2'b11, 1'b1, 7'd50};
    vecs[24] = '{2'b00, 7'd0,  7'd0,  1'b0, 3'd0, 3'd0, 2'b11, 1'b1, 7'd51};
    vecs[25] = '{2'b00, 7'd0,  7'd0,  1'b0, 3'd0, 3'd0, 2'b11, 1'b0, 7'd51};
    vecs[26] = '{2'b01, 7'd60, 7'd0,  1'b0, 3'd1, 3'd0, 2'b11, 1'b0, 7'd51};

    reset          = 1'b1;
    bus.nuke_rb1   = 1'b0;
    bus.req_valid  = 2'b00;
    bus.req_pkt[0] = '0;
    bus.req_pkt[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en",  64'(bus.wr_en[0]),      64'd0);
    check("rst_wr_pkt", 64'(bus.wr_pkt[0]),     64'd0);
    check("rst_occ0",   64'(bus.q_occ[0]),      64'd0);
    check("rst_occ1",   64'(bus.q_occ[1]),      64'd0);
    check("rst_ready",  64'(bus.req_ready),     64'd3);
    reset = 1'b0;

    // Cycle-exact vectors: contention, rr rotation, single pushes, nuke and rr reset.
    for (int i = 0; i < 27; i++) begin
      cycle(vecs[i].valid, vecs[i].p0, vecs[i].p1, vecs[i].nuke);
      check($sformatf("vec%0d_occ0", i),  64'(bus.q_occ[0]),      64'(vecs[i].e_occ0));
      check($sformatf("vec%0d_occ1", i),  64'(bus.q_occ[1]),      64'(vecs[i].e_occ1));
      check($sformatf("vec%0d_ready", i), 64'(bus.req_ready),     64'(vecs[i].e_ready));
      check($sformatf("vec%0d_wr_en", i), 64'(bus.wr_en[0]),      64'(vecs[i].e_wr_en));
      check($sformatf("vec%0d_pdst", i),  64'(bus.wr_pkt[0].pdst), 64'(vecs[i].e_pdst));
    end
    drain("vec_drain");

    // Backpressure: MEM pushes 12 packets (pointer wraps) while EX stays saturated.
    mem_out_cnt = 0;
    saw_full    = 1'b0;
    ex_n        = 0;
    mem_n       = 0;
    for (int c = 0; c < 80 && mem_n < 12; c++) begin
      v[0] = bus.req_ready[0];
      v[1] = bus.req_ready[1];
      cycle(v, 7'(64 + (ex_n % 32)), 7'(mem_n), 1'b0);
      ex_n  += int'(v[0]);
      mem_n += int'(v[1]);
      if (bus.q_occ[1] == 3'd4 && !bus.req_ready[1]) saw_full = 1'b1;
    end
    check("bp_pushed", 64'(mem_n), 64'd12);
    check("bp_saw_full", 64'(saw_full), 64'd1);
    drain("bp_drain");
    check("bp_mem_out_cnt", 64'(mem_out_cnt), 64'd12);

    // Fairness: nuke puts rr at 0, then both queues stay non-empty -> strict EX/MEM alternation.
    cycle(2'b00, 7'd0, 7'd0, 1'b1);
    for (int c = 0; c < 21; c++) begin
      v[0] = bus.req_ready[0];
      v[1] = bus.req_ready[1];
      cycle(v, 7'(c), 7'(32 + c), 1'b0);
      if (c >= 1) begin
        check("fair_wr_en", 64'(bus.wr_en[0]),          64'd1);
        check("fair_src",   64'(bus.wr_pkt[0].data[24]), 64'((c - 1) % 2));
      end
    end
    drain("fair_drain");

    // Nuke with several entries queued plus a push in the nuke cycle.
    n = 0;
    while (!(bus.q_occ[0] >= 3'd3 && bus.q_occ[1] >= 3'd2) && n < 20) begin
      cycle({bus.req_ready[1], bus.req_ready[0]}, 7'(100 + n), 7'(80 + n), 1'b0);
      n++;
    end
    check("nuke_setup", 64'(bus.q_occ[0] >= 3'd3 && bus.q_occ[1] >= 3'd2), 64'd1);
    cycle({bus.req_ready[1], bus.req_ready[0]}, 7'd126, 7'd127, 1'b1);
    check("nuke_occ0",  64'(bus.q_occ[0]), 64'd0);
    check("nuke_occ1",  64'(bus.q_occ[1]), 64'd0);
    check("nuke_wr_en", 64'(bus.wr_en[0]), 64'd0);
    for (int c = 0; c < 5; c++) begin
      cycle(2'b00, 7'd0, 7'd0, 1'b0);
      check("nuke_quiet", 64'(bus.wr_en[0]), 64'd0);
    end

    // Asynchronous reset between clock edges while a burst is draining.
    for (int c = 0; c < 4; c++) cycle(2'b11, 7'(40 + c), 7'(50 + c), 1'b0);
    @(posedge clk);
    #3;
    check("pre_reset_wr_en", 64'(bus.wr_en[0]), 64'd1);
    reset = 1'b1;
    #1;
    check("areset_wr_en", 64'(bus.wr_en[0]),  64'd0);
    check("areset_ready", 64'(bus.req_ready), 64'd3);
    check("areset_occ0",  64'(bus.q_occ[0]),  64'd0);
    check("areset_occ1",  64'(bus.q_occ[1]),  64'd0);
    sb0.delete();
    sb1.delete();
    @(posedge clk);
    #2;
    reset = 1'b0;

    cycle(2'b01, 7'd99, 7'd0, 1'b0);
    check("post_reset_occ0", 64'(bus.q_occ[0]), 64'd1);
    cycle(2'b00, 7'd0, 7'd0, 1'b0);
    check("post_reset_wr_en", 64'(bus.wr_en[0]),      64'd1);
    check("post_reset_pdst",  64'(bus.wr_pkt[0].pdst), 64'd99);
    drain("final_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/iprf_wb_arb.md
Name: iprf_wb_arb

Overview:
- Arbitrates integer-PRF write-port bandwidth between writeback sources (EX at ex1, MEM at mm5, and future units).
- Each requester pushes into a private skid queue.
- A round-robin scheduler drains up to NUM_WR_PORTS queue heads per cycle onto registered PRF write ports.
- Sits between the execution units and the iprf/rename/rs writeback buses; a nuke flushes all queued writebacks.

Parameters:
- NUM_REQ, 2, number of writeback requesters (index 0 = EX, 1 = MEM).
- NUM_WR_PORTS, 1, number of PRF write ports driven; must be <= NUM_REQ.
- Q_DEPTH, 4, entries per requester queue; power of 2, >= 2.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- nuke_rb1  in  1  ROB nuke valid; flushes all queues and the output stage
- req_valid  in  [NUM_REQ]  writeback push strobe per requester
- req_pkt  in  [NUM_REQ] x $bits(t_prf_wr_pkt)  writeback packet (psrc/pdst id + data)
- req_ready  out  [NUM_REQ]  queue has a free entry this cycle
- wr_en  out  [NUM_WR_PORTS]  PRF write-port enable (registered)
- wr_pkt  out  [NUM_WR_PORTS] x $bits(t_prf_wr_pkt)  PRF write packet (registered)
- q_occ  out  [NUM_REQ] x $clog2(Q_DEPTH+1)  per-queue occupancy

Behaviour:
- Reset (async, active-high): all queues empty; rr_ptr=0; wr_en=0; wr_pkt=0; q_occ=0; req_ready=1.
- req_ready[i] is combinational: q_occ[i] != Q_DEPTH.
  - Pop in the same cycle does not raise ready (no pass-through credit).
  - req_valid[i] while !req_ready[i] is illegal; flagged by assertion; the packet is dropped.
- Queue: circular FIFO with wr/rd pointers of $clog2(Q_DEPTH) bits; pointers wrap modulo Q_DEPTH.
  - Occupancy counter is updated by +push -pop; simultaneous push and pop leaves occupancy unchanged.
  - Push into an empty queue is not eligible for grant until the next cycle.
- Scheduling (every cycle):
  - Scan requesters starting at rr_ptr, ascending, wrapping.
  - Grant the first NUM_WR_PORTS non-empty queues, one pop each.
  - Grant k goes to write port k.
- Output: the granted head is registered into wr_pkt[k]; wr_en[k]=1 the next cycle. Ungranted ports have wr_en=0; wr_pkt holds its old value.
- Latency: push at cycle t -> earliest wr_en at t+2 (queue at t+1, output at t+2).
- rr_ptr update:
  - After any grant, rr_ptr = (index of last granted requester + 1) mod NUM_REQ.
  - No grant: rr_ptr is unchanged.
- Fairness: with all queues continuously non-empty, each requester is granted at least once every ceil(NUM_REQ/NUM_WR_PORTS) cycles.
- Nuke (nuke_rb1=1 at cycle t):
  - All queue occupancies go to 0 at t+1; pointers reset to 0.
  - Pushes at t are discarded.
  - wr_en=0 at t+1.
  - Grants at cycle t are suppressed.
  - rr_ptr is reset to 0.
- Reset mid-operation: immediate return to reset state; in-flight packets are lost.
- Assertions (under ASSERT):
  - No push when not ready.
  - q_occ <= Q_DEPTH.
  - No two ports carry the same requester's grant in one cycle.

Optional Feature:
- IPRF_WB_ARB_PERF_EN defined adds the following outputs:
  - perf_stall_cnt [NUM_REQ] x 32: counts cycles with q_occ[i]!=0 and no grant to i; saturating.
  - perf_full_cnt [NUM_REQ] x 32: counts cycles with req_ready[i]=0; saturating.
  - Both counters clear on reset only, not on nuke.
- IPRF_WB_ARB_PERF_EN undefined: these ports and counters do not exist; other behaviour is identical.

Test Plan:
- Single push, idle: req_valid[0]=1 pkt.pdst=5 at cycle 10 -> wr_en[0]=1, wr_pkt.pdst=5 at cycle 12; q_occ[0] returns to 0 at 12.
- Simultaneous contention: both requesters push at cycle 10 (pdst 3 EX, 7 MEM), rr_ptr=0, 1 port -> pdst 3 at cycle 12, pdst 7 at cycle 13; rr_ptr=0 afterwards.
- Fill and backpressure: push MEM every cycle while EX is saturated, Q_DEPTH=4 -> req_ready[1]=0 after 4 net entries; no drop; FIFO order preserved across pointer wrap (push 8 pkts, pdst 0..7 observed in order).
- Fairness: both queues always non-empty for 20 cycles -> grants alternate EX, MEM, EX, MEM...; no requester waits more than 2 cycles.
- Nuke: queues with occ 3/2 plus a push on nuke cycle -> q_occ=0 and wr_en=0 next cycle; no stale pdst appears later.
- Async reset mid-burst: assert reset between clock edges -> wr_en drops to 0 immediately; req_ready=1 for all requesters.
